// File: rtl/decode_stage_if.sv
// Handshake and field bundle between the fetch side, the decode stage,
// the writeback path and the downstream execute stage.
interface decode_stage_if #(
  parameter int WORD_SIZE  = 32,
  parameter int REGNO_BITS = 4,
  parameter int FUNC_BITS  = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [WORD_SIZE-1:0]  in_instr;
  logic                  wb_valid;
  logic [REGNO_BITS-1:0] wb_regno;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [FUNC_BITS:0]    out_alu_func;
  logic                  out_alu_in2_mux;
  logic [REGNO_BITS-1:0] out_regno1;
  logic [REGNO_BITS-1:0] out_regno2;
  logic [WORD_SIZE-1:0]  out_imm;
  logic                  out_wrt_en;
  logic [REGNO_BITS-1:0] out_wrt_regno;
  logic                  out_illegal;

  modport master (
    output in_valid, in_instr, wb_valid, wb_regno, flush, out_ready,
    input  in_ready, out_valid, out_alu_func, out_alu_in2_mux, out_regno1,
           out_regno2, out_imm, out_wrt_en, out_wrt_regno, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, wb_valid, wb_regno, flush, out_ready,
    output in_ready, out_valid, out_alu_func, out_alu_in2_mux, out_regno1,
           out_regno2, out_imm, out_wrt_en, out_wrt_regno, out_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// Instruction decode stage: field decode, register scoreboard for RAW/WAW
// hazards, and a single-entry output register with valid/ready handshake.
module decode_stage #(
  parameter int WORD_SIZE  = 32,
  parameter int REGNO_BITS = 4,
  parameter int FUNC_BITS  = 4
) (
  input logic          clk,
  input logic          reset_n,
  decode_stage_if.slave bus
);
  localparam int NREGS = 2 ** REGNO_BITS;
  localparam int FW    = FUNC_BITS + 1;

  localparam logic [3:0] OP_ALUR = 4'hC;
  localparam logic [3:0] OP_ALUI = 4'h4;
  localparam logic [3:0] OP_CMPR = 4'hD;
  localparam logic [3:0] OP_CMPI = 4'h5;

  localparam logic [3:0] FN_ADD  = 4'h0;
  localparam logic [3:0] FN_SUB  = 4'h1;
  localparam logic [3:0] FN_AND  = 4'h4;
  localparam logic [3:0] FN_OR   = 4'h5;
  localparam logic [3:0] FN_XOR  = 4'h6;
  localparam logic [3:0] FN_NAND = 4'hC;
  localparam logic [3:0] FN_NOR  = 4'hD;
  localparam logic [3:0] FN_XNOR = 4'hE;
  localparam logic [3:0] FN_MVHI = 4'hB;

  localparam logic [3:0] FN_F    = 4'h0;
  localparam logic [3:0] FN_EQ   = 4'h1;
  localparam logic [3:0] FN_LT   = 4'h2;
  localparam logic [3:0] FN_LTE  = 4'h3;
  localparam logic [3:0] FN_T    = 4'h8;
  localparam logic [3:0] FN_NE   = 4'h9;
  localparam logic [3:0] FN_GTE  = 4'hA;
  localparam logic [3:0] FN_GT   = 4'hB;

  // Shared ALU function codes: MSB selects the comparator unit.
  localparam logic [FUNC_BITS:0] ALU_ADD  = FW'(5'h00);
  localparam logic [FUNC_BITS:0] ALU_SUB  = FW'(5'h01);
  localparam logic [FUNC_BITS:0] ALU_AND  = FW'(5'h04);
  localparam logic [FUNC_BITS:0] ALU_OR   = FW'(5'h05);
  localparam logic [FUNC_BITS:0] ALU_XOR  = FW'(5'h06);
  localparam logic [FUNC_BITS:0] ALU_NAND = FW'(5'h0C);
  localparam logic [FUNC_BITS:0] ALU_NOR  = FW'(5'h0D);
  localparam logic [FUNC_BITS:0] ALU_XNOR = FW'(5'h0E);
  localparam logic [FUNC_BITS:0] ALU_MVHI = FW'(5'h0B);
  localparam logic [FUNC_BITS:0] ALU_F    = FW'(5'h10);
  localparam logic [FUNC_BITS:0] ALU_EQ   = FW'(5'h11);
  localparam logic [FUNC_BITS:0] ALU_LT   = FW'(5'h12);
  localparam logic [FUNC_BITS:0] ALU_LTE  = FW'(5'h13);
  localparam logic [FUNC_BITS:0] ALU_T    = FW'(5'h18);
  localparam logic [FUNC_BITS:0] ALU_NE   = FW'(5'h19);
  localparam logic [FUNC_BITS:0] ALU_GTE  = FW'(5'h1A);
  localparam logic [FUNC_BITS:0] ALU_GT   = FW'(5'h1B);

  localparam logic ALUIN2_REG = 1'b0;
  localparam logic ALUIN2_IMM = 1'b1;

  typedef enum logic {ST_EMPTY, ST_FULL} state_t;

  function automatic logic signed [WORD_SIZE-1:0] sext_imm(input logic signed [15:0] imm);
    logic signed [WORD_SIZE-1:0] ext;
    ext = imm;
    return ext;
  endfunction

  function automatic logic [NREGS-1:0] reg_mask(input logic en, input logic [REGNO_BITS-1:0] r);
    return en ? (NREGS'(1) << r) : '0;
  endfunction

  state_t state_q, state_d;

  logic [3:0]                  fn_p0, opc_p0;
  logic signed [15:0]          imm_raw_p0;
  logic [REGNO_BITS-1:0]       rd_p0, rs1_p0, rs2_p0;
  logic                        is_alu_p0, is_cmp_p0, fn_ok_p0, legal_p0;
  logic                        in2_sel_p0;
  logic [FUNC_BITS:0]          code_p0;
  logic [FUNC_BITS:0]          func_p0;
  logic                        mux_p0, wen_p0;
  logic signed [WORD_SIZE-1:0] imm_p0;

  logic [NREGS-1:0] busy_p1, busy_eff, busy_nxt;
  logic             hazard, in_ready_c, accept;

  logic                        vld_p1;
  logic [FUNC_BITS:0]          func_p1;
  logic                        mux_p1, wen_p1, illegal_p1;
  logic [REGNO_BITS-1:0]       rs1_p1, rs2_p1, rd_p1;
  logic signed [WORD_SIZE-1:0] imm_p1;

  // ---- p0: field extraction and combinational decode ----
  assign fn_p0      = bus.in_instr[31:28];
  assign opc_p0     = bus.in_instr[27:24];
  assign imm_raw_p0 = bus.in_instr[23:8];
  assign rs2_p0     = bus.in_instr[8 +: REGNO_BITS];
  assign rs1_p0     = bus.in_instr[4 +: REGNO_BITS];
  assign rd_p0      = bus.in_instr[0 +: REGNO_BITS];
  assign imm_p0     = sext_imm(imm_raw_p0);

  always_comb begin
    is_alu_p0  = 1'b0;
    is_cmp_p0  = 1'b0;
    in2_sel_p0 = ALUIN2_REG;
    code_p0    = '0;
    fn_ok_p0   = 1'b0;
    case (opc_p0)
      OP_ALUR: is_alu_p0 = 1'b1;
      OP_ALUI: begin is_alu_p0 = 1'b1; in2_sel_p0 = ALUIN2_IMM; end
      OP_CMPR: is_cmp_p0 = 1'b1;
      OP_CMPI: begin is_cmp_p0 = 1'b1; in2_sel_p0 = ALUIN2_IMM; end
      default: ;
    endcase
    if (is_alu_p0) begin
      fn_ok_p0 = 1'b1;
      case (fn_p0)
        FN_ADD:  code_p0 = ALU_ADD;
        FN_SUB:  code_p0 = ALU_SUB;
        FN_AND:  code_p0 = ALU_AND;
        FN_OR:   code_p0 = ALU_OR;
        FN_XOR:  code_p0 = ALU_XOR;
        FN_NAND: code_p0 = ALU_NAND;
        FN_NOR:  code_p0 = ALU_NOR;
        FN_XNOR: code_p0 = ALU_XNOR;
        FN_MVHI: code_p0 = ALU_MVHI;
        default: fn_ok_p0 = 1'b0;
      endcase
    end else if (is_cmp_p0) begin
      fn_ok_p0 = 1'b1;
      case (fn_p0)
        FN_F:    code_p0 = ALU_F;
        FN_EQ:   code_p0 = ALU_EQ;
        FN_LT:   code_p0 = ALU_LT;
        FN_LTE:  code_p0 = ALU_LTE;
        FN_T:    code_p0 = ALU_T;
        FN_NE:   code_p0 = ALU_NE;
        FN_GTE:  code_p0 = ALU_GTE;
        FN_GT:   code_p0 = ALU_GT;
        default: fn_ok_p0 = 1'b0;
      endcase
    end
    legal_p0 = fn_ok_p0;
    func_p0  = legal_p0 ? code_p0 : '0;
    mux_p0   = legal_p0 ? in2_sel_p0 : 1'b0;
    wen_p0   = legal_p0;
  end

  // A register retiring this cycle no longer blocks; illegal ops skip the check.
  assign busy_eff = busy_p1 & ~reg_mask(bus.wb_valid, bus.wb_regno);
  assign hazard   = legal_p0 &&
                    (busy_eff[rs1_p0] || busy_eff[rd_p0] ||
                     (in2_sel_p0 == ALUIN2_REG && busy_eff[rs2_p0]));

  assign in_ready_c   = reset_n && !bus.flush &&
                        (state_q == ST_EMPTY || bus.out_ready) && !hazard;
  assign accept       = bus.in_valid && in_ready_c;
  assign bus.in_ready = in_ready_c;

  always_comb begin
    busy_nxt = busy_eff;
    if (accept && legal_p0) busy_nxt[rd_p0] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n || bus.flush) busy_p1 <= '0;
    else                       busy_p1 <= busy_nxt;
  end

  // ---- p1: output register state ----
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= ST_EMPTY;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL:  if (!accept && bus.out_ready) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
    if (bus.flush) state_d = ST_EMPTY;
  end

  assign vld_p1 = (state_q == ST_FULL);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      func_p1    <= '0;
      mux_p1     <= 1'b0;
      rs1_p1     <= '0;
      rs2_p1     <= '0;
      imm_p1     <= '0;
      wen_p1     <= 1'b0;
      rd_p1      <= '0;
      illegal_p1 <= 1'b0;
    end else if (accept) begin
      func_p1    <= func_p0;
      mux_p1     <= mux_p0;
      rs1_p1     <= rs1_p0;
      rs2_p1     <= rs2_p0;
      imm_p1     <= imm_p0;
      wen_p1     <= wen_p0;
      rd_p1      <= rd_p0;
      illegal_p1 <= !legal_p0;
    end
  end

  assign bus.out_valid       = vld_p1;
  assign bus.out_alu_func    = func_p1;
  assign bus.out_alu_in2_mux = mux_p1;
  assign bus.out_regno1      = rs1_p1;
  assign bus.out_regno2      = rs2_p1;
  assign bus.out_imm         = imm_p1;
  assign bus.out_wrt_en      = wen_p1;
  assign bus.out_wrt_regno   = rd_p1;
  assign bus.out_illegal     = illegal_p1;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: table of single-instruction decodes plus
// hand-written hazard, stall, flush and reset sequences.
module tb_decode_stage;
  logic clk = 1'b0;
  logic reset_n;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  decode_stage_if bus ();
  decode_stage dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  func;
    logic        mux;
    logic [31:0] imm;
    logic        wen;
    logic        ill;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
  } vec_t;

  vec_t vecs [13];

  function automatic logic [31:0] mk(input logic [3:0] fn, input logic [3:0] op,
                                     input logic [15:0] imm, input logic [3:0] rs1,
                                     input logic [3:0] rd);
    return {fn, op, imm, rs1, rd};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_flush();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b1;
    tick();
    bus.flush    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{mk(4'h0, 4'hC, 16'h0002, 4'h1, 4'h3), 5'h00, 1'b0, 32'h00000002, 1'b1, 1'b0, 4'h3, 4'h1, 4'h2};
    vecs[1]  = '{mk(4'h1, 4'h4, 16'h8000, 4'h2, 4'h4), 5'h01, 1'b1, 32'hFFFF8000, 1'b1, 1'b0, 4'h4, 4'h2, 4'h0};
    vecs[2]  = '{mk(4'h4, 4'h4, 16'h7FFF, 4'h0, 4'h5), 5'h04, 1'b1, 32'h00007FFF, 1'b1, 1'b0, 4'h5, 4'h0, 4'hF};
    vecs[3]  = '{mk(4'hE, 4'hC, 16'h0009, 4'h7, 4'h8), 5'h0E, 1'b0, 32'h00000009, 1'b1, 1'b0, 4'h8, 4'h7, 4'h9};
    vecs[4]  = '{mk(4'hB, 4'hC, 16'h1234, 4'hA, 4'hB), 5'h0B, 1'b0, 32'h00001234, 1'b1, 1'b0, 4'hB, 4'hA, 4'h4};
    vecs[5]  = '{mk(4'h2, 4'hD, 16'h0006, 4'h5, 4'h1), 5'h12, 1'b0, 32'h00000006, 1'b1, 1'b0, 4'h1, 4'h5, 4'h6};
    vecs[6]  = '{mk(4'hB, 4'h5, 16'hFFFF, 4'h3, 4'h2), 5'h1B, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 4'h2, 4'h3, 4'hF};
    vecs[7]  = '{mk(4'h8, 4'h5, 16'h0100, 4'h0, 4'h0), 5'h18, 1'b1, 32'h00000100, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0};
    vecs[8]  = '{mk(4'h0, 4'h0, 16'hABCD, 4'hC, 4'hD), 5'h00, 1'b0, 32'hFFFFABCD, 1'b0, 1'b1, 4'hD, 4'hC, 4'hD};
    vecs[9]  = '{mk(4'h2, 4'hC, 16'h0003, 4'h1, 4'h2), 5'h00, 1'b0, 32'h00000003, 1'b0, 1'b1, 4'h2, 4'h1, 4'h3};
    vecs[10] = '{mk(4'h4, 4'hD, 16'h0003, 4'h1, 4'h2), 5'h00, 1'b0, 32'h00000003, 1'b0, 1'b1, 4'h2, 4'h1, 4'h3};
    vecs[11] = '{mk(4'hD, 4'h4, 16'h00F0, 4'hF, 4'hE), 5'h0D, 1'b1, 32'h000000F0, 1'b1, 1'b0, 4'hE, 4'hF, 4'h0};
    vecs[12] = '{mk(4'h9, 4'hD, 16'h0000, 4'h4, 4'h6), 5'h19, 1'b0, 32'h00000000, 1'b1, 1'b0, 4'h6, 4'h4, 4'h0};

    reset_n       = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = mk(4'h0, 4'hC, 16'h0002, 4'h1, 4'h3);
    bus.wb_valid  = 1'b0;
    bus.wb_regno  = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    tick();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_imm", bus.out_imm, 32'd0);
    chk("rst_func", 32'(bus.out_alu_func), 32'd0);
    chk("rst_wrt_regno", 32'(bus.out_wrt_regno), 32'd0);
    bus.in_valid = 1'b0;
    reset_n      = 1'b1;
    tick();

    for (int i = 0; i < 13; i++) begin
      bus.in_instr  = vecs[i].instr;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      #1;
      chk($sformatf("v%0d_in_ready", i), 32'(bus.in_ready), 32'd1);
      tick();
      bus.in_valid = 1'b0;
      chk($sformatf("v%0d_out_valid", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("v%0d_func", i), 32'(bus.out_alu_func), 32'(vecs[i].func));
      chk($sformatf("v%0d_mux", i), 32'(bus.out_alu_in2_mux), 32'(vecs[i].mux));
      chk($sformatf("v%0d_imm", i), bus.out_imm, vecs[i].imm);
      chk($sformatf("v%0d_wen", i), 32'(bus.out_wrt_en), 32'(vecs[i].wen));
      chk($sformatf("v%0d_illegal", i), 32'(bus.out_illegal), 32'(vecs[i].ill));
      chk($sformatf("v%0d_rd", i), 32'(bus.out_wrt_regno), 32'(vecs[i].rd));
      chk($sformatf("v%0d_rs1", i), 32'(bus.out_regno1), 32'(vecs[i].rs1));
      chk($sformatf("v%0d_rs2", i), 32'(bus.out_regno2), 32'(vecs[i].rs2));
      do_flush();
      chk($sformatf("v%0d_flushed", i), 32'(bus.out_valid), 32'd0);
    end

    // RAW on r3, released by writeback in the same cycle
    bus.in_instr = mk(4'h0, 4'hC, 16'h0002, 4'h1, 4'h3);
    bus.in_valid = 1'b1;
    tick();
    chk("raw_first_valid", 32'(bus.out_valid), 32'd1);
    bus.in_instr = mk(4'h0, 4'hC, 16'h0000, 4'h3, 4'h4);
    #1;
    chk("raw_block0", 32'(bus.in_ready), 32'd0);
    tick();
    chk("raw_drained", 32'(bus.out_valid), 32'd0);
    chk("raw_block1", 32'(bus.in_ready), 32'd0);
    tick();
    chk("raw_block2", 32'(bus.in_ready), 32'd0);
    bus.wb_valid = 1'b1;
    bus.wb_regno = 4'd3;
    #1;
    chk("raw_wb_release", 32'(bus.in_ready), 32'd1);
    tick();
    bus.wb_valid = 1'b0;
    bus.in_valid = 1'b0;
    chk("raw_acc_valid", 32'(bus.out_valid), 32'd1);
    chk("raw_acc_rs1", 32'(bus.out_regno1), 32'd3);
    chk("raw_acc_rd", 32'(bus.out_wrt_regno), 32'd4);
    bus.in_instr = mk(4'h0, 4'hC, 16'h0000, 4'h0, 4'h4);
    #1;
    chk("waw_block", 32'(bus.in_ready), 32'd0);
    bus.in_instr = mk(4'h0, 4'h4, 16'h0004, 4'h0, 4'h5);
    #1;
    chk("alui_no_rs2", 32'(bus.in_ready), 32'd1);
    bus.in_instr = mk(4'h0, 4'hC, 16'h0004, 4'h0, 4'h5);
    #1;
    chk("alur_rs2_block", 32'(bus.in_ready), 32'd0);
    bus.in_instr = mk(4'h0, 4'hF, 16'h0000, 4'h4, 4'h4);
    #1;
    chk("illegal_no_hazard", 32'(bus.in_ready), 32'd1);
    do_flush();

    // set of busy[rd] wins over a same-cycle writeback clear
    bus.in_instr = mk(4'h0, 4'hC, 16'h0000, 4'h0, 4'h3);
    bus.in_valid = 1'b1;
    bus.wb_valid = 1'b1;
    bus.wb_regno = 4'd3;
    #1;
    chk("setwin_accept", 32'(bus.in_ready), 32'd1);
    tick();
    bus.wb_valid = 1'b0;
    bus.in_instr = mk(4'h0, 4'hC, 16'h0000, 4'h3, 4'h6);
    #1;
    chk("setwin_busy", 32'(bus.in_ready), 32'd0);
    do_flush();

    // downstream stall for 3 cycles
    bus.in_instr  = mk(4'h5, 4'h4, 16'h0ABC, 4'h1, 4'h6);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.in_instr  = mk(4'h0, 4'hC, 16'h0009, 4'h8, 4'h7);
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("stall%0d_ready", k), 32'(bus.in_ready), 32'd0);
      chk($sformatf("stall%0d_valid", k), 32'(bus.out_valid), 32'd1);
      chk($sformatf("stall%0d_imm", k), bus.out_imm, 32'h00000ABC);
      chk($sformatf("stall%0d_func", k), 32'(bus.out_alu_func), 32'h05);
      chk($sformatf("stall%0d_rd", k), 32'(bus.out_wrt_regno), 32'd6);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("stall_release_ready", 32'(bus.in_ready), 32'd1);
    chk("stall_release_rd", 32'(bus.out_wrt_regno), 32'd6);
    tick();
    bus.in_valid = 1'b0;
    chk("stall_next_valid", 32'(bus.out_valid), 32'd1);
    chk("stall_next_rd", 32'(bus.out_wrt_regno), 32'd7);
    chk("stall_next_rs1", 32'(bus.out_regno1), 32'd8);
    tick();
    chk("stall_drain", 32'(bus.out_valid), 32'd0);
    do_flush();

    // illegal op leaves the scoreboard alone
    bus.in_instr = mk(4'h0, 4'h7, 16'h0000, 4'h0, 4'h5);
    bus.in_valid = 1'b1;
    tick();
    chk("ill_flag", 32'(bus.out_illegal), 32'd1);
    chk("ill_wen", 32'(bus.out_wrt_en), 32'd0);
    bus.in_instr = mk(4'h0, 4'hC, 16'h0000, 4'h5, 4'h5);
    #1;
    chk("ill_no_busy", 32'(bus.in_ready), 32'd1);
    tick();

    // flush while FULL with busy[5], competing with in_valid
    bus.out_ready = 1'b0;
    bus.flush     = 1'b1;
    bus.in_instr  = mk(4'h0, 4'hC, 16'h0000, 4'h1, 4'h1);
    #1;
    chk("flush_blocks", 32'(bus.in_ready), 32'd0);
    tick();
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk("flush_empty", 32'(bus.out_valid), 32'd0);
    bus.in_instr = mk(4'h0, 4'hC, 16'h0005, 4'h5, 4'h5);
    #1;
    chk("flush_clears_busy", 32'(bus.in_ready), 32'd1);
    tick();
    chk("flush_no_accept", 32'(bus.out_valid), 32'd0);

    // reset while stalled discards the held instruction
    bus.in_instr = mk(4'h1, 4'h4, 16'h8000, 4'h2, 4'h9);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("rstmid_held", 32'(bus.out_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rstmid_ready", 32'(bus.in_ready), 32'd0);
    tick();
    reset_n = 1'b1;
    chk("rstmid_valid", 32'(bus.out_valid), 32'd0);
    chk("rstmid_imm", bus.out_imm, 32'd0);
    chk("rstmid_func", 32'(bus.out_alu_func), 32'd0);
    chk("rstmid_wen", 32'(bus.out_wrt_en), 32'd0);
    chk("rstmid_rd", 32'(bus.out_wrt_regno), 32'd0);
    bus.in_instr = mk(4'h0, 4'hC, 16'h0000, 4'h9, 4'h1);
    #1;
    chk("rstmid_busy_clear", 32'(bus.in_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
